aes_cipher_collector: RTL and testbench
=======================================

// Module: aes_cipher_collector
// PURPOSE
//  Downstream of the HLS AES core (ap_ctrl_hs). Starts one encryption and captures the ciphertext
//  bytes written on the core's two cipher_text memory ports into a register file.
//  Presents the completed block as one flat word on a valid/ready handshake to the UART TX controller.
// PARAMETERS
//  DATA_W          8     width of each cipher_text_d port (bits per element)
//  DEPTH           16    elements per AES block
//  ADDR_W          7     width of cipher_text_address ports; only addr < DEPTH is legal
//  TIMEOUT_CYCLES  4096  watchdog limit, used only with AES_COLLECT_TIMEOUT_EN
// PORTS
//  clk                   in   1               system clock
//  reset_n               in   1               synchronous, active-low reset
//  start                 in   1               one-cycle request from plaintext loader (BRAM filled)
//  ap_start              out  1               to AES core
//  ap_ready              in   1               from AES core
//  ap_done               in   1               from AES core
//  cipher_text_ce0/we0   in   1 each          port 0 enable / write enable
//  cipher_text_address0  in   ADDR_W          port 0 address
//  cipher_text_d0        in   DATA_W          port 0 data
//  cipher_text_ce1/we1/address1/d1  in  as port 0   port 1
//  data_combined         out  DATA_W*DEPTH    element k at [k*DATA_W +: DATA_W]
//  o_valid               out  1               data_combined valid
//  o_ready               in   1               UART TX accepts
//  busy                  out  1               state != IDLE
//  err_incomplete        out  1               sticky: ap_done seen with unwritten elements
//  err_addr              out  1               sticky: write with address >= DEPTH
//  timeout               out  1               one-cycle pulse, macro only (tied 0 otherwise)
// BEHAVIOUR
//  Clock and reset: one clock (clk). reset_n is synchronous, active-low; sampled on posedge clk only.
//  Reset (reset_n=0 at posedge): state=IDLE; all outputs 0; data_combined=0; written-mask=0.
//  Reset mid-operation aborts the run; captured data is discarded.
//  IDLE: start=1 -> RUN; clear written-mask (data regs keep old values). start is ignored in all other states.
//  RUN: ap_start=1, held until ap_ready=1 is sampled.
//   - ap_ready sampled: next cycle ap_start=0, state=WAIT_DONE.
//   - Writes arriving in RUN are captured as in WAIT_DONE.
//  WAIT_DONE: each port with ce&we=1 and addr<DEPTH writes reg[addr] and sets mask[addr].
//   - Both ports writing the same address in one cycle: port 1 wins.
//   - addr>=DEPTH: write dropped; err_addr<=1.
//   - ap_done=1: -> OUT. A write in the same cycle as ap_done is captured.
//   - Leaving WAIT_DONE with mask != all-ones: err_incomplete<=1.
//  OUT: o_valid=1; data_combined stable; writes ignored.
//   - o_ready=1 sampled: o_valid=0 next cycle, state=IDLE.
//   - o_ready may be high before o_valid; transfer occurs on the first cycle both are high.
//  Latency: o_valid rises 1 cycle after ap_done is sampled. Next start is accepted the cycle after the handshake.
//  Sticky errors are cleared by reset or by an accepted start.
// CONFIGURATION
//  AES_COLLECT_TIMEOUT_EN defined:
//   - 32-bit counter is cleared on entering RUN and increments in RUN/WAIT_DONE.
//   - At TIMEOUT_CYCLES-1: timeout pulses 1 cycle, ap_start=0, state=IDLE, no o_valid.
//  Not defined: no counter; timeout tied 0; the block waits for ap_done indefinitely.
// STRUCTURE
//  Package aes_uart_pkg: AES_BLOCK_BYTES=16, collector_state_t enum {IDLE,RUN,WAIT_DONE,OUT}.
//  Sub-module cipher_capture_regfile: DEPTH x DATA_W storage with two write ports, port-1 priority,
//  per-element written mask, mask clear, and flat read-out.
//  The FSM, handshake logic and watchdog stay in this module.
// TESTING
//  1. start; ap_ready after 3 cycles; core writes FIPS-197 ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, bytes 0..15 on alternating ports, then ap_done
//     -> o_valid 1 cycle later; data_combined[7:0]=8'h69, [127:120]=8'h5a; errors 0.
//  2. Port 0 writes addr 3=8'hAA and port 1 writes addr 3=8'h55 in the same cycle -> element 3=8'h55.
//  3. ap_done after only 15 elements written -> o_valid=1, err_incomplete=1; next start clears it.
//  4. Write to addr 16 -> err_addr=1, no element changed. Hold o_ready=0 for 10 cycles -> data_combined stable,
//     o_valid stays 1; set o_ready=1 -> IDLE.
//  5. reset_n=0 during WAIT_DONE -> next cycle all outputs 0, IDLE. start while busy -> ignored.
//  6. With AES_COLLECT_TIMEOUT_EN and TIMEOUT_CYCLES=64, never assert ap_done -> timeout pulse at cycle 63, IDLE, o_valid never set.

Source files
------------

// File: rtl/aes_uart_pkg.sv
// Shared types and sizes for the AES ciphertext collector and its UART-side consumer.
package aes_uart_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_DONE,
    OUT
  } collector_state_t;

endpackage

// File: rtl/cipher_capture_regfile.sv
// DEPTH x DATA_W capture storage with two write ports (port 1 wins on a collision),
// a per-element written mask with synchronous clear, and a flat read-out.
module cipher_capture_regfile #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 7
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clr_mask,
  input  logic                     en,
  input  logic                     ce0,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        addr0,
  input  logic [DATA_W-1:0]        d0,
  input  logic                     ce1,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        addr1,
  input  logic [DATA_W-1:0]        d1,
  output logic [DATA_W*DEPTH-1:0]  data_flat,
  output logic [DEPTH-1:0]         mask_next,
  output logic                     bad_addr
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             mask;
  logic [DEPTH-1:0]             hit0;
  logic [DEPTH-1:0]             hit1;
  logic                         wr0;
  logic                         wr1;

  assign wr0 = en & ce0 & we0;
  assign wr1 = en & ce1 & we1;

  // Out-of-range addresses never match an element, so they are dropped here.
  always_comb begin
    hit0 = '0;
    hit1 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit0[k] = wr0 && (int'(addr0) == k);
      hit1[k] = wr1 && (int'(addr1) == k);
    end
  end

  assign bad_addr  = (wr0 && (int'(addr0) >= DEPTH)) || (wr1 && (int'(addr1) >= DEPTH));
  assign mask_next = clr_mask ? '0 : (mask | hit0 | hit1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem  <= '0;
      mask <= '0;
    end else begin
      mask <= mask_next;
      for (int k = 0; k < DEPTH; k++) begin
        if (hit1[k])      mem[k] <= d1;
        else if (hit0[k]) mem[k] <= d0;
      end
    end
  end

  assign data_flat = mem;

endmodule

// File: rtl/aes_cipher_collector.sv
// Starts one AES encryption, captures the ciphertext written on the core's two memory ports,
// and offers the block on a valid/ready handshake. Optional watchdog: AES_COLLECT_TIMEOUT_EN.
module aes_cipher_collector
  import aes_uart_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int DEPTH          = AES_BLOCK_BYTES,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  output logic                    ap_start,
  input  logic                    ap_ready,
  input  logic                    ap_done,
  input  logic                    cipher_text_ce0,
  input  logic                    cipher_text_we0,
  input  logic [ADDR_W-1:0]       cipher_text_address0,
  input  logic [DATA_W-1:0]       cipher_text_d0,
  input  logic                    cipher_text_ce1,
  input  logic                    cipher_text_we1,
  input  logic [ADDR_W-1:0]       cipher_text_address1,
  input  logic [DATA_W-1:0]       cipher_text_d1,
  output logic [DATA_W*DEPTH-1:0] data_combined,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic                    busy,
  output logic                    err_incomplete,
  output logic                    err_addr,
  output logic                    timeout
);

  // state     | meaning
  // IDLE      | waiting for start
  // RUN       | ap_start high until ap_ready; writes already captured
  // WAIT_DONE | capturing writes until ap_done
  // OUT       | block presented on o_valid until o_ready
  collector_state_t state, state_nxt;

  logic             start_acc;
  logic             capture;
  logic             leave_wait;
  logic             tmo;
  logic             bad_addr;
  logic [DEPTH-1:0] mask_next;

  assign start_acc = (state == IDLE) && start;
  assign capture   = (state == RUN) || (state == WAIT_DONE);

`ifdef AES_COLLECT_TIMEOUT_EN
  logic [31:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n)       wd_cnt <= '0;
    else if (start_acc) wd_cnt <= '0;
    else if (capture)   wd_cnt <= wd_cnt + 32'd1;
  end

  assign tmo = capture && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog: constant 0 (the comparison is never true).
  assign tmo = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = RUN;
      RUN: begin
        if (tmo)           state_nxt = IDLE;
        else if (ap_ready) state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tmo)          state_nxt = IDLE;
        else if (ap_done) state_nxt = OUT;
      end
      OUT:       if (o_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign leave_wait = (state == WAIT_DONE) && (state_nxt != WAIT_DONE);

  // mask_next includes writes landing in the ap_done cycle itself.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_incomplete <= 1'b0;
      err_addr       <= 1'b0;
    end else if (start_acc) begin
      err_incomplete <= 1'b0;
      err_addr       <= 1'b0;
    end else begin
      if (bad_addr)                         err_addr       <= 1'b1;
      if (leave_wait && (mask_next != '1))  err_incomplete <= 1'b1;
    end
  end

  cipher_capture_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_mask  (start_acc),
    .en        (capture),
    .ce0       (cipher_text_ce0),
    .we0       (cipher_text_we0),
    .addr0     (cipher_text_address0),
    .d0        (cipher_text_d0),
    .ce1       (cipher_text_ce1),
    .we1       (cipher_text_we1),
    .addr1     (cipher_text_address1),
    .d1        (cipher_text_d1),
    .data_flat (data_combined),
    .mask_next (mask_next),
    .bad_addr  (bad_addr)
  );

  assign ap_start = (state == RUN);
  assign o_valid  = (state == OUT);
  assign busy     = (state != IDLE);
  assign timeout  = tmo;

endmodule

// File: tb/tb_aes_cipher_collector.sv
// Randomised scoreboard bench for aes_cipher_collector; the timeout scenario runs only
// when AES_COLLECT_TIMEOUT_EN is defined.
module tb_aes_cipher_collector;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 7;
  localparam int TMO    = 64;
  localparam int FLAT_W = DATA_W * DEPTH;

  logic              clk = 1'b0;
  logic              reset_n, start, ap_ready, ap_done, o_ready;
  logic              ce0, we0, ce1, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] d0, d1;
  logic              ap_start, o_valid, busy, err_incomplete, err_addr, timeout;
  logic [FLAT_W-1:0] data_combined;

  always #5 clk = ~clk;

  aes_cipher_collector #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ap_start(ap_start),
    .ap_ready(ap_ready), .ap_done(ap_done),
    .cipher_text_ce0(ce0), .cipher_text_we0(we0),
    .cipher_text_address0(addr0), .cipher_text_d0(d0),
    .cipher_text_ce1(ce1), .cipher_text_we1(we1),
    .cipher_text_address1(addr1), .cipher_text_d1(d1),
    .data_combined(data_combined), .o_valid(o_valid), .o_ready(o_ready),
    .busy(busy), .err_incomplete(err_incomplete), .err_addr(err_addr),
    .timeout(timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [FLAT_W-1:0] data;
    logic              e_inc;
    logic              e_addr;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  m_mem[DEPTH];
  bit          m_wr[DEPTH];
  bit          m_eaddr;

  task automatic chk(string name, logic [FLAT_W-1:0] act, logic [FLAT_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: a byte array plus the set of written indices for the current block.
  task automatic m_start();
    for (int k = 0; k < DEPTH; k++) m_wr[k] = 1'b0;
    m_eaddr = 1'b0;
  endtask

  task automatic m_reset();
    for (int k = 0; k < DEPTH; k++) m_mem[k] = 8'h00;
    m_start();
  endtask

  task automatic m_write(bit c, bit w, int a, logic [7:0] d);
    if (!(c && w)) return;
    if (a < DEPTH) begin
      m_mem[a] = d;
      m_wr[a]  = 1'b1;
    end else begin
      m_eaddr = 1'b1;
    end
  endtask

  function automatic logic [FLAT_W-1:0] m_flat();
    logic [FLAT_W-1:0] r;
    for (int k = 0; k < DEPTH; k++) r[k*DATA_W +: DATA_W] = m_mem[k];
    return r;
  endfunction

  function automatic bit m_all();
    for (int k = 0; k < DEPTH; k++) if (!m_wr[k]) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor: pops one expectation per o_valid episode, then checks data stays stable.
  bit                in_out = 1'b0;
  logic [FLAT_W-1:0] held;
  exp_t              mon_e;

  always @(negedge clk) begin
    if (o_valid) begin
      if (!in_out) begin
        in_out = 1'b1;
        held   = data_combined;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got o_valid=1 expected no block pending (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("block_data", data_combined, mon_e.data);
          chk("block_err_incomplete", FLAT_W'(err_incomplete), FLAT_W'(mon_e.e_inc));
          chk("block_err_addr", FLAT_W'(err_addr), FLAT_W'(mon_e.e_addr));
        end
      end else begin
        chk("data_stable", data_combined, held);
      end
    end else begin
      in_out = 1'b0;
    end
  end

  // All drivers change inputs on the falling edge.
  task automatic begin_run(int rdy_delay);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_start();
    chk("ap_start_rise", FLAT_W'(ap_start), 1);
    chk("errors_cleared_on_start", FLAT_W'({err_incomplete, err_addr}), 0);
    repeat (rdy_delay) @(negedge clk);
    chk("ap_start_held", FLAT_W'(ap_start), 1);
    ap_ready = 1'b1;
    @(negedge clk);
    ap_ready = 1'b0;
    chk("ap_start_drop", FLAT_W'(ap_start), 0);
  endtask

  task automatic wr_cycle(bit c0, bit w0, int a0, logic [7:0] v0,
                          bit c1, bit w1, int a1, logic [7:0] v1, bit done);
    exp_t e;
    ce0 = c0; we0 = w0; addr0 = ADDR_W'(a0); d0 = v0;
    ce1 = c1; we1 = w1; addr1 = ADDR_W'(a1); d1 = v1;
    ap_done = done;
    m_write(c0, w0, a0, v0);
    m_write(c1, w1, a1, v1);
    if (done) begin
      e.data   = m_flat();
      e.e_inc  = !m_all();
      e.e_addr = m_eaddr;
      exp_q.push_back(e);
    end
    @(negedge clk);
    ce0 = 1'b0; we0 = 1'b0; ce1 = 1'b0; we1 = 1'b0; ap_done = 1'b0;
    if (done) chk("valid_latency", FLAT_W'(o_valid), 1);
  endtask

  task automatic finish_out(int hold);
    repeat (hold) @(negedge clk);
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    chk("valid_drop", FLAT_W'(o_valid), 0);
    chk("idle_after_handshake", FLAT_W'(busy), 0);
  endtask

  function automatic int rnd_addr();
    if ($urandom_range(15, 0) == 0) return int'($urandom_range(127, 16));
    return int'($urandom_range(15, 0));
  endfunction

  logic [7:0] fips[DEPTH] = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
                              8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: got no finish expected finish within time limit");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    int miss;
    reset_n = 1'b0; start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0; o_ready = 1'b0;
    ce0 = 0; we0 = 0; ce1 = 0; we1 = 0; addr0 = '0; addr1 = '0; d0 = '0; d1 = '0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", FLAT_W'({ap_start, o_valid, busy, err_incomplete, err_addr, timeout}), 0);
    chk("reset_data", data_combined, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // FIPS-197 ciphertext, bytes on alternating ports.
    begin_run(3);
    for (int i = 0; i < DEPTH; i++) begin
      if (i % 2 == 0) wr_cycle(1, 1, i, fips[i], 0, 0, 0, 8'h00, 0);
      else            wr_cycle(0, 0, 0, 8'h00, 1, 1, i, fips[i], 0);
    end
    wr_cycle(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1);
    chk("fips_byte0", FLAT_W'(data_combined[7:0]), FLAT_W'(8'h69));
    chk("fips_byte15", FLAT_W'(data_combined[127:120]), FLAT_W'(8'h5a));
    chk("fips_errors", FLAT_W'({err_incomplete, err_addr}), 0);
    finish_out(2);

    // Same-address collision, port 1 wins; final write lands with ap_done.
    begin_run(1);
    for (int i = 0; i < DEPTH / 2; i++)
      wr_cycle(1, 1, 2*i, 8'($urandom), 1, 1, 2*i+1, 8'($urandom), 0);
    wr_cycle(1, 1, 3, 8'hAA, 1, 1, 3, 8'h55, 1);
    chk("collision_elem3", FLAT_W'(data_combined[31:24]), FLAT_W'(8'h55));
    finish_out(0);

    // Only 15 elements written.
    miss = int'($urandom_range(DEPTH-1, 0));
    begin_run(0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == miss) continue;
      if (i % 2 == 0) wr_cycle(1, 1, i, 8'($urandom), 0, 0, 0, 8'h00, 0);
      else            wr_cycle(0, 0, 0, 8'h00, 1, 1, i, 8'($urandom), 0);
    end
    wr_cycle(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 1);
    chk("incomplete_flag", FLAT_W'(err_incomplete), 1);
    finish_out(1);

    // Out-of-range write, long back-pressure, writes and start in OUT ignored.
    begin_run(2);
    for (int i = 0; i < DEPTH; i++) wr_cycle(1, 1, i, 8'($urandom), 0, 0, 0, 8'h00, 0);
    wr_cycle(0, 0, 0, 8'h00, 1, 1, 16, 8'hEE, 1);
    chk("err_addr_flag", FLAT_W'(err_addr), 1);
    for (int i = 0; i < 10; i++) begin
      ce0 = 1'b1; we0 = 1'b1; addr0 = ADDR_W'(i); d0 = 8'($urandom);
      start = (i == 4);
      @(negedge clk);
      chk("valid_held", FLAT_W'(o_valid), 1);
    end
    ce0 = 1'b0; we0 = 1'b0; start = 1'b0;
    finish_out(0);
    @(negedge clk);
    chk("start_in_out_ignored", FLAT_W'(busy), 0);

    // Reset during WAIT_DONE; start while busy ignored.
    begin_run(1);
    wr_cycle(1, 1, 0, 8'h12, 1, 1, 1, 8'h34, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy_ignored_apstart", FLAT_W'(ap_start), 0);
    chk("start_busy_still_busy", FLAT_W'(busy), 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrun_reset_outputs", FLAT_W'({ap_start, o_valid, busy, err_incomplete, err_addr, timeout}), 0);
    chk("midrun_reset_data", data_combined, '0);
    reset_n = 1'b1;
    m_reset();
    @(negedge clk);

    // Randomised blocks.
    for (int t = 0; t < 25; t++) begin
      int  ncyc;
      bit  pre;
      begin_run(int'($urandom_range(5, 0)));
      ncyc = int'($urandom_range(24, 4));
      pre  = ($urandom_range(1, 0) == 1);
      for (int c = 0; c <= ncyc; c++) begin
        int a0, a1;
        a0 = rnd_addr();
        a1 = ($urandom_range(3, 0) == 0) ? a0 : rnd_addr();
        if (c == ncyc && pre) o_ready = 1'b1;
        wr_cycle($urandom_range(3, 0) != 0, $urandom_range(4, 0) != 0, a0, 8'($urandom),
                 $urandom_range(3, 0) != 0, $urandom_range(4, 0) != 0, a1, 8'($urandom),
                 c == ncyc);
      end
      finish_out(pre ? 0 : int'($urandom_range(4, 0)));
    end

`ifdef AES_COLLECT_TIMEOUT_EN
    begin
      int cyc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      m_start();
      cyc = 0;
      while (!timeout && cyc < 200) begin
        ap_ready = (cyc == 3);
        @(negedge clk);
        ap_ready = 1'b0;
        cyc++;
      end
      chk("timeout_cycle", FLAT_W'(cyc), FLAT_W'(TMO - 1));
      @(negedge clk);
      chk("timeout_after", FLAT_W'({timeout, busy, o_valid, ap_start}), 0);
    end
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", FLAT_W'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
